// File: rtl/led_blink_if.sv
// LED arbiter bus bundle: requester requests and counts in; grant, status and LED drive out.
interface led_blink_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned CNT_W = 4
) ();
    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] count;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  done;
    logic                  out;

    modport master (output req, output count, input grant, input busy, input done, input out);
    modport slave  (input req, input count, output grant, output busy, output done, output out);
endinterface

// File: rtl/led_blink_arbiter.sv
// Round-robin, non-preemptive sharing of one status LED; the winner gets N blinks then a gap.
module led_blink_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned HALF  = 8388608,
    parameter int unsigned GAP   = 16777216
) (
    input  logic        clk,
    input  logic        rst_n,
    led_blink_if.slave  bus
);
    localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned MAXP   = (HALF > GAP) ? HALF : GAP;
    localparam int unsigned TICK_W = (MAXP > 1) ? $clog2(MAXP) : 1;
    localparam logic [TICK_W-1:0] HALF_M1 = TICK_W'(HALF - 1);
    localparam logic [TICK_W-1:0] GAP_M1  = TICK_W'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_e;

    state_e              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                out_q, out_d;

    logic                win_valid_c;
    logic [PTR_W-1:0]    win_idx_c;
    logic [PTR_W-1:0]    win_next_c;
    logic [NREQ-1:0]     win_oh_c;
    logic [CNT_W-1:0]    win_cnt_c;
    int unsigned         cand_c;

    // First requester at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        cand_c      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand_c = (32'(ptr_q) + i) % NREQ;
            if (!win_valid_c && bus.req[PTR_W'(cand_c)]) begin
                win_valid_c = 1'b1;
                win_idx_c   = PTR_W'(cand_c);
            end
        end
    end

    // Winner's one-hot grant, its blink count and the pointer that follows it.
    always_comb begin
        win_oh_c  = '0;
        win_cnt_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_valid_c && (win_idx_c == PTR_W'(i))) begin
                win_oh_c[i] = 1'b1;
                win_cnt_c   = bus.count[i*CNT_W +: CNT_W];
            end
        end
        win_next_c = (win_idx_c == PTR_W'(NREQ - 1)) ? '0 : win_idx_c + PTR_W'(1);
    end

    // Sequencer: outputs are decoded from the next state so they land registered with it.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;

        unique case (state_q)
            S_IDLE: begin
                tick_d  = '0;
                grant_d = '0;
                if (win_valid_c) begin
                    grant_d = win_oh_c;
                    rem_d   = win_cnt_c;
                    ptr_d   = win_next_c;
                    state_d = (win_cnt_c != '0) ? S_ON : S_GAP;
                end
            end
            S_ON: begin
                if (tick_q == HALF_M1) begin
                    tick_d  = '0;
                    state_d = S_OFF;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_OFF: begin
                if (tick_q == HALF_M1) begin
                    tick_d  = '0;
                    rem_d   = rem_q - CNT_W'(1);
                    state_d = (rem_q != CNT_W'(1)) ? S_ON : S_GAP;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_GAP: begin
                if (tick_q == GAP_M1) begin
                    tick_d  = '0;
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                tick_d  = '0;
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        out_d  = (state_d == S_ON);
        done_d = (state_d == S_GAP) && (tick_d == GAP_M1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.out   = out_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench: dut_a runs HALF=2/GAP=3, dut_b runs HALF=1/GAP=1; both share clock and reset.
module tb_led_blink_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    led_blink_if #(.NREQ(4), .CNT_W(4)) ifa ();
    led_blink_if #(.NREQ(4), .CNT_W(4)) ifb ();

    led_blink_arbiter #(.NREQ(4), .CNT_W(4), .HALF(2), .GAP(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    led_blink_arbiter #(.NREQ(4), .CNT_W(4), .HALF(1), .GAP(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        int          bad_a, bad_b, ndone, pulses, done_k;
        logic        prev, dn;
        logic [12:1] b_out, b_done, b_grant;
        logic [3:0]  eg;

        rst_n = 1'b0;
        ifa.req = '0; ifa.count = '0;
        ifb.req = '0; ifb.count = '0;

        // Reset and idle
        repeat (3) cyc();
        chk("reset_a", {25'd0, ifa.grant, ifa.busy, ifa.done, ifa.out}, 32'd0);
        chk("reset_b", {25'd0, ifb.grant, ifb.busy, ifb.done, ifb.out}, 32'd0);
        rst_n = 1'b1;
        bad_a = 0; bad_b = 0;
        repeat (100) begin
            cyc();
            if ({ifa.grant, ifa.busy, ifa.done, ifa.out} !== 7'd0) bad_a++;
            if ({ifb.grant, ifb.busy, ifb.done, ifb.out} !== 7'd0) bad_b++;
        end
        chk("idle_a_nonzero_cycles", bad_a, 0);
        chk("idle_b_nonzero_cycles", bad_b, 0);

        // Single burst on dut_a: count0=2, HALF=2, GAP=3
        b_out   = 12'b0000_0011_0011;
        b_done  = 12'b0100_0000_0000;
        b_grant = 12'b0111_1111_1111;
        ifa.count = 16'h0002;
        ifa.req   = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k == 1) ifa.req = 4'b0000;
            chk($sformatf("burst_grant_k%0d", k), ifa.grant, b_grant[k] ? 4'b0001 : 4'b0000);
            chk($sformatf("burst_out_k%0d", k),   ifa.out,   b_out[k]);
            chk($sformatf("burst_done_k%0d", k),  ifa.done,  b_done[k]);
            chk($sformatf("burst_busy_k%0d", k),  ifa.busy,  b_grant[k]);
        end

        // Round robin on dut_b: all request, all counts 1
        ifb.count = 16'h1111;
        ifb.req   = 4'b1111;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            eg = (((k - 1) % 4) == 3) ? 4'b0000 : 4'(4'b0001 << (((k - 1) / 4) % 4));
            chk($sformatf("rr_grant_k%0d", k), ifb.grant, eg);
            chk($sformatf("rr_out_k%0d", k),   ifb.out,   ((k - 1) % 4) == 0);
            chk($sformatf("rr_busy_k%0d", k),  ifb.busy,  eg != 4'b0000);
        end
        ifb.req = 4'b0000;
        repeat (3) cyc();
        chk("rr_drain_grant", ifb.grant, 4'b0000);

        // Zero count on dut_a: requester 2, gap-only burst
        ifa.count = 16'h0000;
        ifa.req   = 4'b0100;
        ndone = 0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 1) ifa.req = 4'b0000;
            ndone += int'(ifa.done);
            chk($sformatf("zero_grant_k%0d", k), ifa.grant, (k <= 3) ? 4'b0100 : 4'b0000);
            chk($sformatf("zero_out_k%0d", k),   ifa.out,   1'b0);
        end
        chk("zero_done_pulses", ndone, 1);

        // Request dropped after grant on dut_b: count1=3 still fully runs
        ifb.count = 16'h0030;
        ifb.req   = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 1) ifb.req = 4'b0000;
            chk($sformatf("drop_grant_k%0d", k), ifb.grant, (k <= 7) ? 4'b0010 : 4'b0000);
            chk($sformatf("drop_out_k%0d", k),   ifb.out,   (k == 1) || (k == 3) || (k == 5));
            chk($sformatf("drop_done_k%0d", k),  ifb.done,  k == 7);
        end

        // Reset mid-burst on dut_b: requester 2 in ON, pointer would be 3 afterwards
        ifb.count = 16'h0200;
        ifb.req   = 4'b0100;
        cyc();
        chk("rst_pre_grant", ifb.grant, 4'b0100);
        chk("rst_pre_out",   ifb.out,   1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_out",   ifb.out,   1'b0);
        chk("rst_async_grant", ifb.grant, 4'b0000);
        chk("rst_async_busy",  ifb.busy,  1'b0);
        ifb.req   = 4'b1010;
        ifb.count = 16'h0010;
        dn = 1'b0;
        repeat (2) begin
            cyc();
            dn = dn | ifb.done;
        end
        chk("rst_no_done", dn, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk("rst_after_grant", ifb.grant, 4'b0010);
        chk("rst_after_out",   ifb.out,   1'b1);
        ifb.req = 4'b0000;
        repeat (3) cyc();
        chk("rst_after_idle", ifb.grant, 4'b0000);

        // Max count on dut_b: 15 blinks, burst spans 31 cycles
        ifb.count = 16'h000F;
        ifb.req   = 4'b0001;
        pulses = 0; done_k = 0; ndone = 0; prev = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (k == 1) ifb.req = 4'b0000;
            if (ifb.out && !prev) pulses++;
            prev = ifb.out;
            ndone += int'(ifb.done);
            if (ifb.done && done_k == 0) done_k = k;
            if (k == 32) chk("max_grant_after_done", ifb.grant, 4'b0000);
        end
        chk("max_pulses", pulses, 15);
        chk("max_done_cycle", done_k, 31);
        chk("max_done_count", ndone, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_blink_arbiter.md
# led_blink_arbiter

Shares a single blinking status LED among `NREQ` requesters. Each requester asks for a burst of N blinks. A round-robin, non-preemptive arbiter grants the LED to one requester at a time. A sequencer FSM then drives the LED through N on/off periods and a trailing gap before releasing it. The block sits between status sources (PLL lock, config done, error flags, etc.) and the top-level `out` LED pin; it replaces a free-running counter bit as the LED driver.

## Interface
- `NREQ`, 4: number of requesters, ≥2.
- `CNT_W`, 4: width of each per-requester blink count.
- `HALF`, 8388608: cycles per LED on-phase and per off-phase, ≥1.
- `GAP`, 16777216: cycles LED is held off after the last blink of a burst, ≥1.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NREQ: level request per requester.
- `count` in NREQ*CNT_W: blink count; requester i uses bits [i*CNT_W +: CNT_W].
- `grant` out NREQ: one-hot owner of the LED; all-zero when idle.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `done` out 1: one-cycle pulse at the end of each granted burst.
- `out` out 1: LED drive, registered.

## Operation
- Reset values:
  - `out`=0, `grant`=0, `busy`=0, `done`=0.
  - FSM=IDLE, round-robin pointer=0, tick counter=0, remaining=0.
- FSM states: IDLE, ON, OFF, GAP.
- **IDLE:**
  - If any `req` bit is set, select the first set index searching from the pointer upward, modulo NREQ.
  - Register the one-hot `grant` and latch that requester's `count` into `remaining`.
  - Set the pointer to (winner+1) mod NREQ.
  - Next state is ON if the latched count is non-zero, otherwise GAP.
  - With no request, stay in IDLE with all outputs 0.
- **ON:** `out`=1 for HALF cycles, then go to OFF.
- **OFF:** `out`=0 for HALF cycles; `remaining` decrements on exit.
  - Go to ON if the decremented value is non-zero.
  - Otherwise go to GAP.
- **GAP:** `out`=0 for GAP cycles.
  - `done`=1 in the last GAP cycle.
  - Next state is IDLE; `grant` clears on entry to IDLE.
- Tick counter:
  - Width is $clog2 of the larger of HALF and GAP.
  - Loads 0 on every state entry.
  - The state exits when tick == (phase length − 1).
- Non-preemptive: changes to `req` or `count` after grant are ignored until the burst completes.
  - If the granted requester drops `req` mid-burst, the burst still completes.
- Count 0 gives a gap-only burst: GAP cycles with `out`=0, `grant` held, then `done`.
- Maximum count is 2^CNT_W − 1 blinks; there is no wrap.
- Asynchronous reset mid-burst:
  - All outputs return to 0 immediately.
  - The pointer returns to 0 and the burst is abandoned.
  - No `done` is issued.

## Timing
- `req` sampled high in IDLE at edge t gives `grant`, `busy` and `out`=1 (count≠0) from cycle t+1.
- Burst length from first grant cycle to last `done` cycle: count*2*HALF + GAP cycles.
- `grant` deasserts one cycle after `done`, with exactly one IDLE cycle between bursts.
  - A next request pending during that IDLE cycle is granted on the following cycle.
- `busy` is high on exactly the cycles `grant` is non-zero.
- `grant` is registered and never has more than one bit set.

## Test plan
- **Reset and idle:** hold `rst_n`=0, then release with `req`=0 for 100 cycles → `out`, `grant`, `busy` and `done` stay 0.
- **Single burst:** HALF=2, GAP=3, `req`=0001, count0=2, `req` sampled at cycle t.
  - `grant`=0001 from t+1.
  - `out`=1 at t+1..t+2 and t+5..t+6; 0 at t+3..t+4 and t+7..t+11.
  - `done` at t+11; `grant`=0 at t+12.
- **Round robin:** `req`=1111 held, all counts=1, HALF=1, GAP=1.
  - Grants occur in order 0001, 0010, 0100, 1000, 0001.
  - Grants are 4 cycles apart: 3 busy cycles plus 1 idle cycle.
- **Zero count and request drop:**
  - Count=0 → `grant` held for GAP cycles, `out` stays 0, one `done` pulse.
  - Dropping `req` mid-burst with count=3 → all 3 blinks plus the gap still complete.
- **Reset mid-burst:** assert `rst_n`=0 during ON → `out`=0 and `grant`=0 asynchronously, no `done`; after release with `req`=0010, requester 1 is granted (pointer back at 0).
- **Max count:** count=15, HALF=1, GAP=1 → exactly 15 high pulses, `done` 31 cycles after grant start.
